// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, merge arbiter FSM states and source select type.
package noc_pkg;

   localparam int unsigned FLIT_W        = 9;
   localparam int unsigned FLIT_TAIL_BIT = FLIT_W - 1;

   typedef enum logic [1:0] {
      IDLE,
      LOCK0,
      LOCK1
   } arb_state_t;

   typedef logic source_t;

endpackage

// File: rtl/flit_out_reg.sv
// One-entry valid/ready output register carrying a flit and its source select.
module flit_out_reg
   import noc_pkg::*;
#(
   parameter int unsigned W = FLIT_W
) (
   input  logic         CLK,
   input  logic         _RESET,
   input  logic         in_load,
   input  logic [W-1:0] in_data,
   input  source_t      in_src,
   input  logic         out_ready,
   output logic         load,
   output logic [W-1:0] out_data,
   output source_t      out_src,
   output logic         out_valid
);

   logic [W-1:0] data_q;
   source_t      src_q;
   logic         valid_q;

   assign load      = !valid_q || out_ready;
   assign out_data  = data_q;
   assign out_src   = src_q;
   assign out_valid = valid_q;

   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         data_q  <= '0;
         src_q   <= 1'b0;
         valid_q <= 1'b0;
      end else if (in_load) begin
         data_q  <= in_data;
         src_q   <= in_src;
         valid_q <= 1'b1;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/merge_arbiter.sv
// Two-input round-robin packet merge with atomic packet forwarding.
// Optional per-input completed-packet counters are enabled with MERGE_ARB_STATS_EN.
module merge_arbiter
   import noc_pkg::*;
#(
   parameter int unsigned W     = FLIT_W,
   parameter int unsigned CNT_W = 16
) (
   input  logic             CLK,
   input  logic             _RESET,
   input  logic [W-1:0]     in0_data,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic [W-1:0]     in1_data,
   input  logic             in1_valid,
   output logic             in1_ready,
   output logic [W-1:0]     out_data,
   output source_t          S,
   output logic             out_valid,
   input  logic             out_ready
`ifdef MERGE_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0] pkt_cnt0,
   output logic [CNT_W-1:0] pkt_cnt1
`endif
);

   arb_state_t state_q, state_d;
   logic       last_q, last_d;
   logic       own0, own1;
   logic       load;
   logic       xfer0, xfer1;
   logic       tail0, tail1;

   assign tail0 = in0_data[W-1];
   assign tail1 = in1_data[W-1];

   // Ready is gated by reset so upstream never sees an accept while held in reset.
   assign in0_ready = own0 && load && _RESET;
   assign in1_ready = own1 && load && _RESET;
   assign xfer0     = in0_valid && in0_ready;
   assign xfer1     = in1_valid && in1_ready;

   always_comb begin
      own0    = 1'b0;
      own1    = 1'b0;
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            own0 = in0_valid && (!in1_valid || last_q);
            own1 = in1_valid && !own0;
         end
         LOCK0:   own0 = 1'b1;
         LOCK1:   own1 = 1'b1;
         default: ;
      endcase
      if (xfer0) begin
         if (tail0) begin
            state_d = IDLE;
            last_d  = 1'b0;
         end else begin
            state_d = LOCK0;
         end
      end else if (xfer1) begin
         if (tail1) begin
            state_d = IDLE;
            last_d  = 1'b1;
         end else begin
            state_d = LOCK1;
         end
      end
   end

   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   flit_out_reg #(
      .W (W)
   ) u_out_reg (
      .CLK       (CLK),
      ._RESET    (_RESET),
      .in_load   (xfer0 || xfer1),
      .in_data   (xfer1 ? in1_data : in0_data),
      .in_src    (source_t'(xfer1)),
      .out_ready (out_ready),
      .load      (load),
      .out_data  (out_data),
      .out_src   (S),
      .out_valid (out_valid)
   );

`ifdef MERGE_ARB_STATS_EN
   logic [CNT_W-1:0] cnt0_q, cnt1_q;

   always_ff @(posedge CLK or negedge _RESET) begin
      if (!_RESET) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (xfer0 && tail0) cnt0_q <= cnt0_q + 1'b1;
         if (xfer1 && tail1) cnt1_q <= cnt1_q + 1'b1;
      end
   end

   assign pkt_cnt0 = cnt0_q;
   assign pkt_cnt1 = cnt1_q;
`else
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_merge_arbiter.sv
// Self-checking bench for merge_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model. Define MERGE_ARB_STATS_EN for counters.
module tb_merge_arbiter;
   import noc_pkg::*;

   localparam int unsigned W = FLIT_W;
`ifdef MERGE_ARB_STATS_EN
   localparam int unsigned CW = 2;
`else
   localparam int unsigned CW = 16;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] in0_data, in1_data, out_data;
   logic         in0_valid, in0_ready, in1_valid, in1_ready;
   logic         out_valid, out_ready;
   source_t      s_out;
`ifdef MERGE_ARB_STATS_EN
   logic [CW-1:0] pkt_cnt0, pkt_cnt1;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   merge_arbiter #(
      .W     (W),
      .CNT_W (CW)
   ) dut (
      .CLK       (clk),
      ._RESET    (rst_n),
      .in0_data  (in0_data),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in1_data  (in1_data),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .out_data  (out_data),
      .S         (s_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef MERGE_ARB_STATS_EN
      ,
      .pkt_cnt0  (pkt_cnt0),
      .pkt_cnt1  (pkt_cnt1)
`endif
   );

   // Behavioural model: owner 0 = none, 1 = input 0 holds the output, 2 = input 1.
   int           m_owner;
   bit           m_last, m_ov, m_s;
   logic [W-1:0] m_od;
   int unsigned  m_c0, m_c1;

   logic [W-1:0] pend0[$];
   logic [W-1:0] pend1[$];

   task automatic model_reset();
      m_owner = 0;
      m_last  = 1'b1;
      m_ov    = 1'b0;
      m_s     = 1'b0;
      m_od    = '0;
      m_c0    = 0;
      m_c1    = 0;
   endtask

   function automatic bit model_ready(int idx);
      if (!rst_n || !(!m_ov || out_ready)) return 1'b0;
      if (m_owner == 1) return idx == 0;
      if (m_owner == 2) return idx == 1;
      if (idx == 0) return in0_valid && (!in1_valid || m_last);
      return in1_valid && (!in0_valid || !m_last);
   endfunction

   task automatic model_clock();
      bit x0, x1;
      x0 = in0_valid && model_ready(0);
      x1 = in1_valid && model_ready(1);
      if (x0 || x1) begin
         m_od = x0 ? in0_data : in1_data;
         m_s  = x1;
         m_ov = 1'b1;
         if (m_od[FLIT_TAIL_BIT]) begin
            m_owner = 0;
            m_last  = x1;
            if (x0) m_c0 = (m_c0 + 1) & ((1 << CW) - 1);
            else    m_c1 = (m_c1 + 1) & ((1 << CW) - 1);
         end else begin
            m_owner = x0 ? 1 : 2;
         end
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      in0_data  = '0;
      in1_data  = '0;
      out_ready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic gen_packet(input int idx);
      int len;
      logic [W-1:0] f;
      len = $urandom_range(1, 4);
      for (int j = 0; j < len; j++) begin
         f = W'($urandom_range(0, 255));
         f[FLIT_TAIL_BIT] = (j == len - 1);
         if (idx == 0) pend0.push_back(f);
         else          pend1.push_back(f);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      out_ready = 1'b1;
      in0_valid = 1'b1;
      in0_data  = 9'h1AA;
      in1_valid = 1'b1;
      in1_data  = 9'h155;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      checks++;
      if (in0_ready !== 1'b0 || in1_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got %b%b want 00", in0_ready, in1_ready);
      end
      checks++;
      if (out_data !== '0 || s_out !== 1'b0) begin
         errors++; $display("FAIL reset_out_data: got %h/%b want 000/0", out_data, s_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in0_ready !== 1'b1 || in1_ready !== 1'b0) begin
         errors++; $display("FAIL first_grant_ready: got %b%b want 10", in0_ready, in1_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 9'h1AA || s_out !== 1'b0) begin
         errors++;
         $display("FAIL first_grant_out: got %b/%h/%b want 1/1aa/0", out_valid, out_data, s_out);
      end
      @(negedge clk);
      in0_valid = 1'b0;
      in1_valid = 1'b0;
   endtask

   task automatic test_contention();
      logic [W-1:0] exp_d;
      apply_reset();
      in0_valid = 1'b1;
      in0_data  = 9'h1AA;
      in1_valid = 1'b1;
      in1_data  = 9'h155;
      for (int i = 0; i < 6; i++) begin
         exp_d = (i % 2 == 1) ? 9'h155 : 9'h1AA;
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_d || s_out !== source_t'(i % 2)) begin
            errors++;
            $display("FAIL contention[%0d]: got %b/%h/%b want 1/%h/%0d", i, out_valid, out_data,
                     s_out, exp_d, i % 2);
         end
      end
      @(negedge clk);
      in0_valid = 1'b0;
      in1_valid = 1'b0;
   endtask

   task automatic test_atomicity();
      logic [W-1:0] pkt [3];
      pkt[0] = 9'h011;
      pkt[1] = 9'h022;
      pkt[2] = 9'h133;
      apply_reset();
      in1_valid = 1'b1;
      in1_data  = 9'h1FF;
      for (int k = 0; k < 3; k++) begin
         in0_valid = 1'b1;
         in0_data  = pkt[k];
         #1;
         checks++;
         if (in1_ready !== 1'b0 || in0_ready !== 1'b1) begin
            errors++;
            $display("FAIL atomic_ready[%0d]: got %b%b want 10", k, in0_ready, in1_ready);
         end
         @(posedge clk);
         #1;
         checks++;
         if (out_data !== pkt[k] || s_out !== 1'b0) begin
            errors++;
            $display("FAIL atomic_out[%0d]: got %h/%b want %h/0", k, out_data, s_out, pkt[k]);
         end
         @(negedge clk);
      end
      in0_valid = 1'b0;
      #1;
      checks++;
      if (in1_ready !== 1'b1) begin
         errors++; $display("FAIL atomic_release: in1_ready got %b want 1", in1_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_data !== 9'h1FF || s_out !== 1'b1) begin
         errors++; $display("FAIL atomic_after: got %h/%b want 1ff/1", out_data, s_out);
      end
      @(negedge clk);
      in1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [W-1:0] pkt [4];
      logic [W-1:0] rcv[$];
      int  k;
      bit  acc;
      pkt[0] = 9'h011;
      pkt[1] = 9'h022;
      pkt[2] = 9'h033;
      pkt[3] = 9'h144;
      apply_reset();
      k = 0;
      for (int c = 0; c < 30 && rcv.size() < 4; c++) begin
         out_ready = !(c >= 2 && c < 6);
         if (k < 4) begin
            in0_valid = 1'b1;
            in0_data  = pkt[k];
         end else begin
            in0_valid = 1'b0;
         end
         #1;
         if (c >= 2 && c < 6) begin
            checks++;
            if (in0_ready !== 1'b0) begin
               errors++; $display("FAIL bp_ready[%0d]: got %b want 0", c, in0_ready);
            end
            checks++;
            if (k < 1 || out_valid !== 1'b1 || out_data !== pkt[(k > 0) ? k - 1 : 0]) begin
               errors++;
               $display("FAIL bp_hold[%0d]: got %b/%h want 1/%h", c, out_valid, out_data,
                        pkt[(k > 0) ? k - 1 : 0]);
            end
         end
         acc = in0_valid && in0_ready;
         if (out_valid && out_ready) rcv.push_back(out_data);
         @(posedge clk);
         if (acc) k++;
         @(negedge clk);
      end
      checks++;
      if (rcv.size() != 4) begin
         errors++; $display("FAIL bp_count: got %0d flits want 4", rcv.size());
      end
      for (int i = 0; i < 4 && i < rcv.size(); i++) begin
         checks++;
         if (rcv[i] !== pkt[i]) begin
            errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, rcv[i], pkt[i]);
         end
      end
      in0_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_no_dup: out_valid got %b want 0", out_valid);
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      in0_valid = 1'b1;
      in0_data  = 9'h011;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 9'h011) begin
         errors++; $display("FAIL mr_header: got %b/%h want 1/011", out_valid, out_data);
      end
      in0_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL mr_async_clear: out_valid got %b want 0", out_valid);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      in1_valid = 1'b1;
      in1_data  = 9'h100;
      #1;
      checks++;
      if (in1_ready !== 1'b1 || in0_ready !== 1'b0) begin
         errors++; $display("FAIL mr_idle_grant: got %b%b want 01", in0_ready, in1_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 9'h100 || s_out !== 1'b1) begin
         errors++;
         $display("FAIL mr_new_pkt: got %b/%h/%b want 1/100/1", out_valid, out_data, s_out);
      end
      @(negedge clk);
      in1_valid = 1'b0;
   endtask

`ifdef MERGE_ARB_STATS_EN
   task automatic test_stats();
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         in1_valid = 1'b1;
         in1_data  = 9'h100 | W'(i);
         @(posedge clk);
         @(negedge clk);
      end
      in1_valid = 1'b0;
      #1;
      checks++;
      if (pkt_cnt1 !== 2'd1 || pkt_cnt0 !== 2'd0) begin
         errors++;
         $display("FAIL stats_wrap: got cnt0=%0d cnt1=%0d want 0/1", pkt_cnt0, pkt_cnt1);
      end
   endtask
`endif

   task automatic test_random();
      bit x0, x1;
      apply_reset();
      pend0.delete();
      pend1.delete();
      x0 = 1'b0;
      x1 = 1'b0;
      for (int c = 0; c < 400; c++) begin
         out_ready = ($urandom % 4) != 0;
         if (!(in0_valid && !x0)) begin
            in0_valid = 1'b0;
            if (pend0.size() == 0 && $urandom % 3 == 0) gen_packet(0);
            if (pend0.size() != 0 && $urandom % 4 != 0) begin
               in0_valid = 1'b1;
               in0_data  = pend0.pop_front();
            end
         end
         if (!(in1_valid && !x1)) begin
            in1_valid = 1'b0;
            if (pend1.size() == 0 && $urandom % 3 == 0) gen_packet(1);
            if (pend1.size() != 0 && $urandom % 4 != 0) begin
               in1_valid = 1'b1;
               in1_data  = pend1.pop_front();
            end
         end
         #1;
         checks++;
         if (in0_ready !== model_ready(0) || in1_ready !== model_ready(1)) begin
            errors++;
            $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", c, in0_ready, in1_ready,
                     model_ready(0), model_ready(1));
         end
         checks++;
         if (out_valid !== m_ov || (m_ov && (out_data !== m_od || s_out !== m_s))) begin
            errors++;
            $display("FAIL rnd_out[%0d]: got %b/%h/%b want %b/%h/%b", c, out_valid, out_data,
                     s_out, m_ov, m_od, m_s);
         end
`ifdef MERGE_ARB_STATS_EN
         checks++;
         if (pkt_cnt0 !== CW'(m_c0) || pkt_cnt1 !== CW'(m_c1)) begin
            errors++;
            $display("FAIL rnd_stats[%0d]: got %0d/%0d want %0d/%0d", c, pkt_cnt0, pkt_cnt1,
                     m_c0, m_c1);
         end
`endif
         x0 = in0_valid && in0_ready;
         x1 = in1_valid && in1_ready;
         @(posedge clk);
         model_clock();
         @(negedge clk);
      end
      in0_valid = 1'b0;
      in1_valid = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      in0_data  = '0;
      in1_data  = '0;
      out_ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_contention();
      test_atomicity();
      test_backpressure();
      test_mid_reset();
`ifdef MERGE_ARB_STATS_EN
      test_stats();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/merge_arbiter.md
# merge_arbiter

Clocked two-input packet merge that consumes the two flit streams produced by the decoder stage (Out0/Out1 side) and serialises them onto one output channel. Packets are forwarded atomically: once a header flit wins arbitration, that input holds the output until its tail flit passes. Inputs are arbitrated round-robin. The block drives a 1-bit select stream `S` identifying the source of each forwarded flit, mirroring the decoder's select channel.

## Interface
Parameters:
- `W`, 9: flit width. Bit `W-1` is the tail flag; bits `W-2:0` are the payload.
- `CNT_W`, 16: width of the statistics counters. Used only when stats are compiled in.

Ports:
- `CLK`  in  1  Single clock. All state updates on the rising edge.
- `_RESET`  in  1  Asynchronous, active-low reset.
- `in0_data`  in  W  Flit on input 0.
- `in0_valid`  in  1  Input 0 holds a flit.
- `in0_ready`  out  1  Input 0 flit is accepted this cycle.
- `in1_data`, `in1_valid`, `in1_ready`  same as input 0, for input 1.
- `out_data`  out  W  Registered output flit.
- `S`  out  1  Registered source of `out_data`: 0 = input 0, 1 = input 1. Valid with `out_valid`.
- `out_valid`  out  1  Output register holds a flit.
- `out_ready`  in  1  Downstream accepts the flit this cycle.
- `pkt_cnt0`, `pkt_cnt1`  out  CNT_W  Completed-packet counts. Present only with `MERGE_ARB_STATS_EN`.

## Operation
- Handshake: a transfer occurs on any edge where `valid && ready` are both high. Data must hold stable while `valid` is high and `ready` is low. Once `valid` is asserted, it does not drop until the transfer.
- Output stage: a one-entry register. `load = !out_valid || out_ready`.
- FSM states:
  - **IDLE**: no packet in flight.
  - **LOCK0**: input 0 owns the output.
  - **LOCK1**: input 1 owns the output.
- **IDLE** behaviour:
  - Candidates are the inputs with `valid` high.
  - With one candidate, that input wins.
  - With two candidates, the input not equal to `last` wins. `last` is a priority bit; its reset value is 1, so input 0 wins first.
  - The winner's `ready = load`, and the winning flit transfers in the same cycle.
  - If the flit's tail bit is 1 (single-flit packet), the FSM stays in IDLE. Otherwise it moves to LOCKx.
- **LOCKx** behaviour:
  - Only input x has `ready = load`. The other input's `ready` is 0.
  - When a flit with tail = 1 transfers, the FSM returns to IDLE.
- `last` updates to x on every tail transfer from input x.
- A flit transfer loads `out_data` and sets `S = x` and `out_valid = 1`.
- If `out_ready` is high and nothing loads, `out_valid` clears.
- A losing or blocked input sees `ready = 0`, with no side effects.
- Both inputs valid with the same tail flit: the `last` rule applies; the loser waits.
- In LOCKx with `inx_valid` low: the output idles and the lock is held. No packet interleaving is allowed.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `S` = 0.
  - `in0_ready` = `in1_ready` = 0 while `_RESET` is low.
  - FSM = IDLE, `last` = 1, counters = 0.
- Latency: input transfer to `out_valid` is 1 cycle.
- Throughput: 1 flit/cycle when `out_ready` is held high, including back-to-back packets from alternating inputs with no idle cycle.
- `inx_ready` is combinational from FSM state, `last`, `valid`, `out_valid` and `out_ready`. There is no combinational path from `in*_data` to any output.
- Reset asserted mid-packet: all state clears immediately and the partial packet is dropped. Upstream and downstream are reset together.

## Configuration
- `MERGE_ARB_STATS_EN` defined:
  - `pkt_cnt0` and `pkt_cnt1` exist.
  - Each increments by 1 on every tail-flit transfer from its input.
  - Counters wrap modulo 2^CNT_W (all-ones + 1 → 0).
- Undefined: the counter ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package `noc_pkg` holds:
  - the `W` default and the tail-bit index constant `FLIT_TAIL_BIT`;
  - the FSM state enum `arb_state_t` {IDLE, LOCK0, LOCK1};
  - the `source_t` typedef for `S`.
- One natural sub-module: `flit_out_reg`, the one-entry valid/ready output register carrying data and `S`.

## Test plan
- **Reset:** hold `_RESET` low, drive both inputs valid → `out_valid` = 0 and both readies = 0. Release → the first grant goes to input 0.
- **Single-flit contention:** both inputs present tail flits 0x1AA and 0x155 continuously, `out_ready` = 1 → output sequence 0x1AA (S = 0), 0x155 (S = 1), alternating every cycle.
- **Packet atomicity:** input 0 sends a 3-flit packet 0x011, 0x022, 0x133 while input 1 holds 0x1FF valid → all input 0 flits emerge consecutively, then 0x1FF. `in1_ready` stays 0 until the tail transfers.
- **Backpressure:** `out_ready` = 0 for 4 cycles mid-packet → `out_data` holds steady, `in0_ready` = 0 after the register fills, and no flit is lost or duplicated when `out_ready` rises.
- **Mid-packet reset:** assert `_RESET` after the header of a 3-flit packet → `out_valid` drops asynchronously. After release, the FSM is in IDLE and a new input 1 tail flit 0x100 is granted.
- **Stats wrap (with `MERGE_ARB_STATS_EN`, `CNT_W` = 2):** 5 single-flit packets on input 1 → `pkt_cnt1` = 1 and `pkt_cnt0` = 0.
